// File: rtl/psc_trigger_conditioner.sv
// EVR trigger conditioner: synchronize, deglitch, delay, stretch, hold off.
// Ports: clk, reset, evr_in, enable, delay_cycles, clr_missed -> trig_out, busy, missed_count.
module psc_trigger_conditioner #(
  parameter int FILTER_LEN     = 4,
  parameter int STRETCH_CYCLES = 60,
  parameter int HOLDOFF_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        evr_in,
  input  logic        enable,
  input  logic [15:0] delay_cycles,
  input  logic        clr_missed,
  output logic        trig_out,
  output logic        busy,
  output logic [7:0]  missed_count
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int SW  = $clog2(STRETCH_CYCLES + 1);
  localparam int HW  = $clog2(HOLDOFF_CYCLES + 1);
  localparam int CW0 = (SW > 16) ? SW : 16;
  localparam int CW  = (HW > CW0) ? HW : CW0;

  localparam logic [FCW-1:0] FLT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [CW-1:0]  STR_LAST = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0]  HLD_LAST = CW'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    PULSE,
    HOLDOFF
  } state_t;

  logic           s1;
  logic           s2;
  logic [FCW-1:0] flt_cnt;
  logic           level;
  logic           evt;

  state_t         state;
  state_t         state_n;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_n;
  logic           miss;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= evr_in;
      s2 <= s1;
    end
  end

  // The level flips on the FILTER_LEN-th consecutive differing sample;
  // any agreeing sample restarts the run. evt fires on the same edge
  // the level rises, so it is a single-cycle strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      flt_cnt <= '0;
      level   <= 1'b0;
      evt     <= 1'b0;
    end else begin
      evt <= (s2 != level) && (flt_cnt == FLT_LAST) && s2;
      if (s2 == level) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        level   <= s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  // cnt holds the remaining cycles minus one for the current state.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    miss    = 1'b0;
    unique case (state)
      IDLE: begin
        if (evt && enable) begin
          if (delay_cycles == 16'd0) begin
            state_n = PULSE;
            cnt_n   = STR_LAST;
          end else begin
            state_n = DELAY;
            cnt_n   = CW'(delay_cycles - 16'd1);
          end
        end
      end
      DELAY: begin
        miss = evt;
        if (cnt == '0) begin
          state_n = PULSE;
          cnt_n   = STR_LAST;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      PULSE: begin
        miss = evt;
        if (cnt == '0) begin
          if (HOLDOFF_CYCLES == 0) begin
            state_n = IDLE;
          end else begin
            state_n = HOLDOFF;
            cnt_n   = HLD_LAST;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      HOLDOFF: begin
        miss = evt;
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up
  // exactly with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      trig_out <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      trig_out <= (state_n == PULSE);
      busy     <= (state_n != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      missed_count <= 8'd0;
    end else if (clr_missed) begin
      missed_count <= 8'd0;
    end else if (miss && (missed_count != 8'hFF)) begin
      missed_count <= missed_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_psc_trigger_conditioner.sv
// Directed self-checking bench for psc_trigger_conditioner.
// Default parameters; clock 50 MHz.
module tb_psc_trigger_conditioner;

  logic        clk;
  logic        reset;
  logic        evr_in;
  logic        enable;
  logic [15:0] delay_cycles;
  logic        clr_missed;
  logic        trig_out;
  logic        busy;
  logic [7:0]  missed_count;

  int tests;
  int fails;

  psc_trigger_conditioner dut (
    .clk          (clk),
    .reset        (reset),
    .evr_in       (evr_in),
    .enable       (enable),
    .delay_cycles (delay_cycles),
    .clr_missed   (clr_missed),
    .trig_out     (trig_out),
    .busy         (busy),
    .missed_count (missed_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    evr_in = 1'b0;
    tick();
    tick();
    tests++;
    if (trig_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_trig got=%b exp=0", trig_out);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    tests++;
    if (missed_count !== 8'd0) begin
      fails++;
      $display("FAIL reset_missed got=%0d exp=0", missed_count);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_basic();
    int first, width, last, bcnt;
    bit ok;
    first = -1; width = 0; last = -1; bcnt = 0;
    enable = 1'b1;
    delay_cycles = 16'd0;
    for (int n = 0; n < 1200; n++) begin
      evr_in = (n < 100);
      tick();
      if (trig_out) begin
        if (first < 0) first = n;
        width++;
        last = n;
      end
      if (busy) bcnt++;
    end
    tests++;
    if (first != 6) begin
      fails++;
      $display("FAIL basic_latency got=%0d exp=6", first);
    end
    tests++;
    if (width != 60) begin
      fails++;
      $display("FAIL basic_width got=%0d exp=60", width);
    end
    tests++;
    if (last != 65) begin
      fails++;
      $display("FAIL basic_last got=%0d exp=65", last);
    end
    tests++;
    if (bcnt != 1060) begin
      fails++;
      $display("FAIL basic_busy got=%0d exp=1060", bcnt);
    end
    tests++;
    if (missed_count !== 8'd0) begin
      fails++;
      $display("FAIL basic_missed got=%0d exp=0", missed_count);
    end
    wait_idle(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL basic_idle got=busy exp=idle");
    end
  endtask

  task automatic test_delay();
    int first, width, bcnt;
    bit ok;
    first = -1; width = 0; bcnt = 0;
    delay_cycles = 16'd25;
    for (int n = 0; n < 1200; n++) begin
      evr_in = (n < 10);
      if (n == 11) delay_cycles = 16'd3;
      tick();
      if (trig_out) begin
        if (first < 0) first = n;
        width++;
      end
      if (busy) bcnt++;
    end
    delay_cycles = 16'd0;
    tests++;
    if (first != 31) begin
      fails++;
      $display("FAIL delay_latency got=%0d exp=31", first);
    end
    tests++;
    if (width != 60) begin
      fails++;
      $display("FAIL delay_width got=%0d exp=60", width);
    end
    tests++;
    if (bcnt != 1085) begin
      fails++;
      $display("FAIL delay_busy got=%0d exp=1085", bcnt);
    end
    wait_idle(ok);
  endtask

  task automatic test_glitch();
    int tseen, bseen;
    tseen = 0; bseen = 0;
    for (int k = 0; k < 20; k++) begin
      for (int j = 0; j < 8; j++) begin
        evr_in = (j < 3);
        tick();
        if (trig_out) tseen++;
        if (busy) bseen++;
      end
    end
    for (int j = 0; j < 20; j++) begin
      tick();
      if (trig_out) tseen++;
      if (busy) bseen++;
    end
    tests++;
    if (tseen != 0) begin
      fails++;
      $display("FAIL glitch_trig got=%0d exp=0", tseen);
    end
    tests++;
    if (bseen != 0) begin
      fails++;
      $display("FAIL glitch_busy got=%0d exp=0", bseen);
    end
    tests++;
    if (missed_count !== 8'd0) begin
      fails++;
      $display("FAIL glitch_missed got=%0d exp=0", missed_count);
    end
  endtask

  task automatic test_missed();
    int rises, second;
    logic prev;
    rises = 0; second = -1; prev = 1'b0;
    for (int n = 0; n < 2500; n++) begin
      evr_in = (n < 10) || (n >= 500 && n < 510) ||
               (n >= 1200 && n < 1210);
      tick();
      if (trig_out && !prev) begin
        rises++;
        if (n >= 1000 && second < 0) second = n;
      end
      prev = trig_out;
    end
    tests++;
    if (rises != 2) begin
      fails++;
      $display("FAIL missed_pulses got=%0d exp=2", rises);
    end
    tests++;
    if (missed_count !== 8'd1) begin
      fails++;
      $display("FAIL missed_count got=%0d exp=1", missed_count);
    end
    tests++;
    if (second != 1206) begin
      fails++;
      $display("FAIL missed_third got=%0d exp=1206", second);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL missed_idle got=%b exp=0", busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_saturate();
    bit ok;
    delay_cycles = 16'd4000;
    for (int n = 0; n < 3210; n++) begin
      evr_in = (n < 10) ||
               (n >= 20 && n < 3020 && ((n - 20) % 10) < 5) ||
               (n >= 3100 && n < 3105);
      clr_missed = (n == 3106);
      if (n == 3099) begin
        tests++;
        if (missed_count !== 8'd255) begin
          fails++;
          $display("FAIL sat_count got=%0d exp=255", missed_count);
        end
      end
      tick();
      if (n == 3106) begin
        tests++;
        if (missed_count !== 8'd0) begin
          fails++;
          $display("FAIL sat_clr got=%0d exp=0", missed_count);
        end
      end
    end
    clr_missed = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL sat_busy got=%b exp=1", busy);
    end
    tests++;
    if (missed_count !== 8'd0) begin
      fails++;
      $display("FAIL sat_after got=%0d exp=0", missed_count);
    end
    delay_cycles = 16'd0;
    wait_idle(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL sat_idle got=busy exp=idle");
    end
  endtask

  task automatic test_reset_mid();
    int tseen, bseen;
    tseen = 0; bseen = 0;
    for (int n = 0; n <= 20; n++) begin
      evr_in = (n < 10);
      tick();
      if (n == 6) begin
        tests++;
        if (trig_out !== 1'b1) begin
          fails++;
          $display("FAIL rmid_pulse got=%b exp=1", trig_out);
        end
      end
    end
    reset = 1'b1;
    tick();
    tests++;
    if (trig_out !== 1'b0) begin
      fails++;
      $display("FAIL rmid_trig got=%b exp=0", trig_out);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL rmid_busy got=%b exp=0", busy);
    end
    reset = 1'b0;
    for (int n = 0; n < 1200; n++) begin
      tick();
      if (trig_out) tseen++;
      if (busy) bseen++;
    end
    tests++;
    if (tseen != 0 || bseen != 0) begin
      fails++;
      $display("FAIL rmid_after got=%0d/%0d exp=0/0", tseen, bseen);
    end
  endtask

  task automatic test_enable_off();
    int tseen, bseen;
    tseen = 0; bseen = 0;
    enable = 1'b0;
    for (int n = 0; n < 100; n++) begin
      evr_in = (n < 10);
      tick();
      if (trig_out) tseen++;
      if (busy) bseen++;
    end
    enable = 1'b1;
    tests++;
    if (tseen != 0 || bseen != 0) begin
      fails++;
      $display("FAIL enoff_pulse got=%0d/%0d exp=0/0", tseen, bseen);
    end
    tests++;
    if (missed_count !== 8'd0) begin
      fails++;
      $display("FAIL enoff_missed got=%0d exp=0", missed_count);
    end
  endtask

  task automatic test_enable_mid();
    int width, bcnt;
    bit ok;
    width = 0; bcnt = 0;
    for (int n = 0; n < 1200; n++) begin
      evr_in = (n < 10);
      if (n == 10) enable = 1'b0;
      tick();
      if (trig_out) width++;
      if (busy) bcnt++;
    end
    enable = 1'b1;
    tests++;
    if (width != 60) begin
      fails++;
      $display("FAIL enmid_width got=%0d exp=60", width);
    end
    tests++;
    if (bcnt != 1060) begin
      fails++;
      $display("FAIL enmid_busy got=%0d exp=1060", bcnt);
    end
    wait_idle(ok);
  endtask

  task automatic test_reset_evr_high();
    int first, rises;
    logic prev;
    bit ok;
    first = -1; rises = 0; prev = 1'b0;
    reset = 1'b1;
    evr_in = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (trig_out && !prev) begin
        rises++;
        if (first < 0) first = n;
      end
      prev = trig_out;
    end
    evr_in = 1'b0;
    tests++;
    if (first != 6) begin
      fails++;
      $display("FAIL rel_latency got=%0d exp=6", first);
    end
    tests++;
    if (rises != 1) begin
      fails++;
      $display("FAIL rel_pulses got=%0d exp=1", rises);
    end
    tests++;
    if (missed_count !== 8'd0) begin
      fails++;
      $display("FAIL rel_missed got=%0d exp=0", missed_count);
    end
    wait_idle(ok);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    evr_in = 1'b0;
    enable = 1'b1;
    delay_cycles = 16'd0;
    clr_missed = 1'b0;
    test_reset();
    test_basic();
    test_delay();
    test_glitch();
    test_missed();
    test_saturate();
    test_reset_mid();
    test_enable_off();
    test_enable_mid();
    test_reset_evr_high();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
